ct_had_dbginfo_rd_ctrl: RTL

- Read sequencer directly downstream of the common debug-info snapshot FIFO in HAD.
- Takes single-word or burst read requests from the HAD IR/DR decode and drives the FIFO's read-enable pulse.
- Captures the FIFO's registered output and presents each word to the DR consumer with a valid/ack handshake.
- Tracks the FIFO read pointer so the FIFO is never read past its depth; enforces the one-cycle pointer-wrap gap.

---
 rtl/ct_had_dbginfo_rd_ctrl_pkg.sv | 14 +
 rtl/ct_had_dbginfo_rd_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/ct_had_dbginfo_rd_ctrl_pkg.sv
// Constants shared by the HAD debug-info snapshot FIFO and its read sequencer.
package ct_had_dbginfo_rd_ctrl_pkg;

    localparam int DBG_WIDTH      = 64;
    localparam int DBG_DEPTH      = 6;
    localparam int DBG_RPTR_WIDTH = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_VALID = 3'd3;
    localparam logic [2:0] ST_WRAP  = 3'd4;

endpackage

// File: rtl/ct_had_dbginfo_rd_ctrl.sv
// Read sequencer for the debug-info snapshot FIFO: single/burst reads, DR handshake,
// and a mirrored read pointer so the FIFO is never read past the end of a snapshot.
//
// state | meaning
// IDLE  | waiting for a single or burst request
// READ  | FIFO read-enable pulse, advance word index
// LOAD  | capture FIFO registered output
// VALID | word presented to DR consumer until rd_ack
// WRAP  | dead cycle after the last word so the FIFO pointer can wrap
module ct_had_dbginfo_rd_ctrl
    import ct_had_dbginfo_rd_ctrl_pkg::*;
(
    input  logic                 forever_cpuclk,
    input  logic                 cpurst_b,
    input  logic                 ir_dbginfo_rd_req,
    input  logic                 ir_dbginfo_burst_req,
    input  logic [DBG_WIDTH-1:0] dbgfifo2_data,
    output logic                 dbgfifo2_read_ren,
    output logic [DBG_WIDTH-1:0] rd_data,
    output logic                 rd_data_vld,
    input  logic                 rd_ack,
    output logic                 rd_last,
    output logic                 rd_busy,
    output logic                 rd_err,
    input  logic                 rd_err_clr
);

    localparam logic [DBG_RPTR_WIDTH-1:0] WIDX_LAST = DBG_RPTR_WIDTH'(DBG_DEPTH - 1);

    logic [2:0]                state;
    logic [DBG_RPTR_WIDTH-1:0] widx;
    logic                      burst;
    logic                      last_flag;
    logic                      req_any;

    assign req_any = ir_dbginfo_rd_req | ir_dbginfo_burst_req;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state     <= ST_IDLE;
            widx      <= '0;
            burst     <= 1'b0;
            last_flag <= 1'b0;
            rd_data   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ir_dbginfo_burst_req) begin
                        state <= ST_READ;
                        burst <= 1'b1;
                    end else if (ir_dbginfo_rd_req) begin
                        state <= ST_READ;
                        burst <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (widx == WIDX_LAST) begin
                        widx      <= '0;
                        last_flag <= 1'b1;
                    end else begin
                        widx      <= widx + 1'b1;
                        last_flag <= 1'b0;
                    end
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    rd_data <= dbgfifo2_data;
                    state   <= ST_VALID;
                end
                ST_VALID: begin
                    if (rd_ack) begin
                        if (last_flag) begin
                            state <= ST_WRAP;
                            burst <= 1'b0;
                        end else if (burst) begin
                            state <= ST_READ;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_WRAP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // A new error outranks a clear arriving in the same cycle.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_err <= 1'b0;
        end else if (req_any && (state != ST_IDLE)) begin
            rd_err <= 1'b1;
        end else if (rd_err_clr) begin
            rd_err <= 1'b0;
        end
    end

    assign dbgfifo2_read_ren = (state == ST_READ);
    assign rd_data_vld       = (state == ST_VALID);
    assign rd_last           = (state == ST_VALID) & last_flag;
    assign rd_busy           = (state != ST_IDLE);

endmodule
